// File: rtl/hazard_pkg.sv
// Shared types for the EX-stage hazard controller: CGRA handshake states,
// the hard-wired zero register index and the load-use match helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        CGRA_REQ  = 2'd1,
        CGRA_WAIT = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // r0 is never a real producer, so a load targeting it cannot create a hazard.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return mem_read && (rd != REG_ZERO) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: ID/EX hazard inputs, CGRA
// handshake and the stall/bubble/flush controls returned to the pipeline.
interface ex_hazard_ctrl_if;

    logic [4:0] id_rs_addr_i;
    logic [4:0] id_rt_addr_i;
    logic       id_uses_rt_i;
    logic       ex_mem_read_i;
    logic [4:0] ex_rd_addr_i;
    logic       ex_cgra_op_i;
    logic       branch_taken_i;
    logic       cgra_ack_i;
    logic       cgra_done_i;

    logic       pc_write_o;
    logic       if_id_write_o;
    logic       if_id_flush_o;
    logic       id_ex_bubble_o;
    logic       ex_hold_o;
    logic       cgra_req_o;
    logic       cgra_timeout_o;

    modport master (
        output id_rs_addr_i, id_rt_addr_i, id_uses_rt_i, ex_mem_read_i, ex_rd_addr_i,
               ex_cgra_op_i, branch_taken_i, cgra_ack_i, cgra_done_i,
        input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, ex_hold_o,
               cgra_req_o, cgra_timeout_o
    );

    modport slave (
        input  id_rs_addr_i, id_rt_addr_i, id_uses_rt_i, ex_mem_read_i, ex_rd_addr_i,
               ex_cgra_op_i, branch_taken_i, cgra_ack_i, cgra_done_i,
        output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, ex_hold_o,
               cgra_req_o, cgra_timeout_o
    );

endinterface

// File: rtl/ex_cgra_wait_fsm.sv
// CGRA request/ack/done sequencer with bounded wait: owns the handshake state,
// the timeout counter, the registered request and the sticky timeout flag.
module ex_cgra_wait_fsm
    import hazard_pkg::*;
#(
    parameter int CGRA_TIMEOUT = 1024,
    parameter int TMO_W        = 16
) (
    input  logic clk_i,
    input  logic start_i,
    input  logic start_req_i,
    input  logic cgra_ack_i,
    input  logic cgra_done_i,
    output logic busy_o,
    output logic complete_o,
    output logic cgra_req_o,
    output logic cgra_timeout_o
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CGRA_TIMEOUT - 1);

    hz_state_e        state_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             done_hit;
    logic             tmo_hit;

    // done without ack in CGRA_REQ is not a completion: the CGRA never took the request.
    always_comb begin
        done_hit = ((state_q == CGRA_REQ) && cgra_ack_i && cgra_done_i) ||
                   ((state_q == CGRA_WAIT) && cgra_done_i);
        tmo_hit  = (state_q != RUN) && (tmo_cnt_q == TMO_LAST);
    end

    assign busy_o     = (state_q != RUN);
    assign complete_o = done_hit || tmo_hit;

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q        <= RUN;
            tmo_cnt_q      <= '0;
            cgra_req_o     <= 1'b0;
            cgra_timeout_o <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (start_req_i) begin
                        state_q    <= CGRA_REQ;
                        tmo_cnt_q  <= '0;
                        cgra_req_o <= 1'b1;
                    end
                end
                CGRA_REQ, CGRA_WAIT: begin
                    if (complete_o) begin
                        state_q    <= RUN;
                        tmo_cnt_q  <= '0;
                        cgra_req_o <= 1'b0;
                        if (!done_hit) cgra_timeout_o <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                        if ((state_q == CGRA_REQ) && cgra_ack_i) begin
                            state_q    <= CGRA_WAIT;
                            cgra_req_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= RUN;
                    cgra_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: branch flush, CGRA stall and load-use bubble.
// Define HAZARD_PERF_CNT_EN to add stall_cnt_o / flush_cnt_o event counters.
module ex_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CGRA_TIMEOUT = 1024,
    parameter int TMO_W        = 16
) (
    input  logic                 clk_i,
    input  logic                 start_i,
    ex_hazard_ctrl_if.slave      hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cnt_o,
    output logic [31:0]          flush_cnt_o
`endif
);

    logic busy;
    logic complete;
    logic cgra_go;
    logic lu_hit;

    assign lu_hit  = load_use_hit(hz.ex_mem_read_i, hz.ex_rd_addr_i, hz.id_rs_addr_i,
                                  hz.id_rt_addr_i, hz.id_uses_rt_i);
    // A taken branch squashes the CGRA op sitting in EX, so it must not start a handshake.
    assign cgra_go = hz.ex_cgra_op_i && !hz.branch_taken_i;

    ex_cgra_wait_fsm #(
        .CGRA_TIMEOUT (CGRA_TIMEOUT),
        .TMO_W        (TMO_W)
    ) u_wait_fsm (
        .clk_i          (clk_i),
        .start_i        (start_i),
        .start_req_i    (cgra_go),
        .cgra_ack_i     (hz.cgra_ack_i),
        .cgra_done_i    (hz.cgra_done_i),
        .busy_o         (busy),
        .complete_o     (complete),
        .cgra_req_o     (hz.cgra_req_o),
        .cgra_timeout_o (hz.cgra_timeout_o)
    );

    always_comb begin
        hz.pc_write_o     = 1'b1;
        hz.if_id_write_o  = 1'b1;
        hz.if_id_flush_o  = 1'b0;
        hz.id_ex_bubble_o = 1'b0;
        hz.ex_hold_o      = 1'b0;
        if (!start_i) begin
            // Hold the front end and inject NOPs while reset is asserted.
            hz.pc_write_o     = 1'b0;
            hz.if_id_write_o  = 1'b0;
            hz.id_ex_bubble_o = 1'b1;
        end else if (busy) begin
            if (!complete) begin
                hz.pc_write_o    = 1'b0;
                hz.if_id_write_o = 1'b0;
                hz.ex_hold_o     = 1'b1;
            end
        end else if (hz.branch_taken_i) begin
            hz.if_id_flush_o  = 1'b1;
            hz.id_ex_bubble_o = 1'b1;
        end else if (hz.ex_cgra_op_i) begin
            hz.pc_write_o    = 1'b0;
            hz.if_id_write_o = 1'b0;
            hz.ex_hold_o     = 1'b1;
        end else if (lu_hit) begin
            hz.pc_write_o     = 1'b0;
            hz.if_id_write_o  = 1'b0;
            hz.id_ex_bubble_o = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, !hz.pc_write_o};
        flush_cnt_d = flush_cnt_q + {31'd0, hz.if_id_flush_o};
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
